// File: rtl/memory_scan_reader_pkg.sv
// Shared definitions for the memory scan reader and its sibling blocks.
//   - default word/address widths of the 4-entry byte memory system
//   - read-side FSM state encoding
//   - settle-timer counter width helper
package memory_scan_reader_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 2;
    localparam int unsigned NUM_WORDS      = 2 ** DEFAULT_ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } scan_state_e;

    // Counter width for a settle time; a 1-cycle settle still needs one bit.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/memory_scan_reader_settle_timer.sv
// Loadable down-counter measuring the address settle time.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load_i      - reload the counter with CYCLES-1
//   en_i        - count down by one (stops at zero)
//   expire_c    - counter is zero (combinational)
module memory_scan_reader_settle_timer
    import memory_scan_reader_pkg::*;
#(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_c
);

    localparam int unsigned       CNT_W    = timer_width(CYCLES);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; counting saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/memory_scan_reader.sv
// Read-side controller for the 4-entry byte memory: drives the address,
// waits a settle time, captures the byte and offers it on a valid/ready port.
// Single read, or a wrapping 4-beat sweep starting at start_addr.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start, sweep, start_addr   - request (sampled in IDLE only)
//   addr, memory               - memory system address out / byte in
//   rd_data, rd_addr, rd_valid - captured beat, held until rd_ready
//   rd_ready                   - consumer accepts the current beat
//   busy, done                 - transaction in flight / final-accept pulse
module memory_scan_reader
    import memory_scan_reader_pkg::*;
#(
    parameter int unsigned DATA_W        = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W        = DEFAULT_ADDR_W,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sweep,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] memory,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       WORDS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(WORDS - 1);

    if (SETTLE_CYCLES == 0) begin : g_bad_settle
        $error("memory_scan_reader: SETTLE_CYCLES must be >= 1");
    end

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic timer_load_c;
    logic timer_en_c;
    logic timer_expire_c;

    memory_scan_reader_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load_c),
        .en_i     (timer_en_c),
        .expire_c (timer_expire_c)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        beat_d       = beat_q;
        rd_data_d    = rd_data_q;
        rd_addr_d    = rd_addr_q;
        rd_valid_d   = rd_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timer_load_c = 1'b0;
        timer_en_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = start_addr;
                    mode_d       = sweep;
                    beat_d       = '0;
                    busy_d       = 1'b1;
                    timer_load_c = 1'b1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                timer_en_c = 1'b1;
                if (timer_expire_c) begin
                    rd_data_d  = memory;
                    rd_addr_d  = addr_q;
                    rd_valid_d = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                // Memory is not re-sampled here; the captured beat is held.
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (mode_q && (beat_q != LAST_BEAT)) begin
                        beat_d       = beat_q + ADDR_W'(1);
                        addr_d       = addr_q + ADDR_W'(1);
                        timer_load_c = 1'b1;
                        state_d      = SETTLE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mode_q     <= 1'b0;
            beat_q     <= '0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            beat_q     <= beat_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign addr     = addr_q;
    assign rd_data  = rd_data_q;
    assign rd_addr  = rd_addr_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_memory_scan_reader.sv
// Bench for memory_scan_reader: two instances (settle 1 and 3 cycles) share
// request inputs; each has its own consumer ready and memory read port.
module tb_memory_scan_reader;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, sweep;
    logic [1:0] start_addr;
    logic [7:0] mem [4];

    logic [1:0] addr_a     [NI];
    logic [7:0] memory_a   [NI];
    logic [7:0] rd_data_a  [NI];
    logic [1:0] rd_addr_a  [NI];
    logic       rd_valid_a [NI];
    logic       busy_a     [NI];
    logic       done_a     [NI];
    logic       rdy        [NI];

    int         st_beats [NI];
    int         st_dones [NI];
    int         st_lat   [NI];
    logic [9:0] st_first [NI];
    logic [9:0] st_last  [NI];

    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int SC = (g == 0) ? 1 : 3;

        memory_scan_reader #(
            .DATA_W        (8),
            .ADDR_W        (2),
            .SETTLE_CYCLES (SC)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .sweep      (sweep),
            .start_addr (start_addr),
            .addr       (addr_a[g]),
            .memory     (memory_a[g]),
            .rd_data    (rd_data_a[g]),
            .rd_addr    (rd_addr_a[g]),
            .rd_valid   (rd_valid_a[g]),
            .rd_ready   (rdy[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g])
        );

        assign memory_a[g] = mem[addr_a[g]];

        // Transaction-level reference: list of addresses to visit, remaining
        // settle cycles before the next capture, and the presented beat.
        logic       m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0;
        logic [1:0] m_base = '0, m_idx = '0, m_drv = '0, m_raddr = '0;
        logic [7:0] m_rdata = '0;
        int         m_total = 0, m_wait = 0;

        always @(posedge clk) begin
            m_done <= 1'b0;
            if (reset) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
                m_drv   <= '0;
                m_raddr <= '0;
                m_rdata <= '0;
                m_wait  <= 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy  <= 1'b1;
                    m_base  <= start_addr;
                    m_idx   <= '0;
                    m_total <= sweep ? 4 : 1;
                    m_wait  <= SC;
                    m_drv   <= start_addr;
                end
            end else if (m_valid) begin
                if (rdy[g]) begin
                    m_valid <= 1'b0;
                    if (int'(m_idx) + 1 >= m_total) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end else begin
                        m_idx  <= m_idx + 2'd1;
                        m_drv  <= 2'(m_base + m_idx + 2'd1);
                        m_wait <= SC;
                    end
                end
            end else begin
                if (m_wait == 1) begin
                    m_valid <= 1'b1;
                    m_rdata <= mem[m_drv];
                    m_raddr <= m_drv;
                end
                m_wait <= m_wait - 1;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk($sformatf("outputs_vs_model[inst%0d]", g),
                    64'({addr_a[g], rd_data_a[g], rd_addr_a[g], rd_valid_a[g], busy_a[g], done_a[g]}),
                    64'({m_drv, m_rdata, m_raddr, m_valid, m_busy, m_done}));
            end
        end

        // Per-transaction statistics used by the vector table.
        int         mon_lat = 0, mon_first_lat = 0, mon_beats = 0, mon_dones = 0;
        logic       mon_got = 1'b0, mon_busy_p = 1'b0;
        logic [9:0] mon_first = '0, mon_last = '0;

        always @(negedge clk) begin
            mon_busy_p <= busy_a[g];
            if (busy_a[g] && !mon_busy_p) begin
                mon_lat       <= 0;
                mon_got       <= 1'b0;
                mon_beats     <= 0;
                mon_dones     <= 0;
                mon_first_lat <= -1;
            end else if (busy_a[g] && !mon_got) begin
                mon_lat <= mon_lat + 1;
                if (rd_valid_a[g]) begin
                    mon_got       <= 1'b1;
                    mon_first_lat <= mon_lat + 1;
                end
            end
            if (rd_valid_a[g] && rdy[g]) begin
                if (mon_beats == 0) mon_first <= {rd_addr_a[g], rd_data_a[g]};
                mon_last  <= {rd_addr_a[g], rd_data_a[g]};
                mon_beats <= mon_beats + 1;
            end
            if (done_a[g]) mon_dones <= mon_dones + 1;
        end

        assign st_beats[g] = mon_beats;
        assign st_dones[g] = mon_dones;
        assign st_lat[g]   = mon_first_lat;
        assign st_first[g] = mon_first;
        assign st_last[g]  = mon_last;
    end

    // Called at a falling edge; start is accepted at the next rising edge.
    task automatic pulse_start(input logic sw, input logic [1:0] sa);
        #1;
        start      = 1'b1;
        sweep      = sw;
        start_addr = sa;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while ((busy_a[0] || busy_a[1]) && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk("wait_idle_bound", 64'({busy_a[0], busy_a[1]}), 64'(2'b00));
    endtask

    task automatic wait_valid(input int k, input int limit);
        int i = 0;
        @(negedge clk);
        while (!rd_valid_a[k] && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("wait_valid[inst%0d]", k), 64'(rd_valid_a[k]), 64'(1'b1));
    endtask

    function automatic logic [7:0] preload(input logic [1:0] a);
        return 8'(8'h11 * (int'(a) + 1));
    endfunction

    typedef struct packed {
        logic       sw;
        logic [1:0] sa;
        logic [2:0] beats;
        logic [9:0] first;
        logic [9:0] last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        reset = 1'b1; start = 1'b0; sweep = 1'b0; start_addr = '0;
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        vecs[0] = '{sw: 1'b0, sa: 2'd1, beats: 3'd1, first: {2'd1, 8'h22}, last: {2'd1, 8'h22}};
        vecs[1] = '{sw: 1'b1, sa: 2'd2, beats: 3'd4, first: {2'd2, 8'h33}, last: {2'd1, 8'h22}};
        vecs[2] = '{sw: 1'b0, sa: 2'd3, beats: 3'd1, first: {2'd3, 8'h44}, last: {2'd3, 8'h44}};
        vecs[3] = '{sw: 1'b1, sa: 2'd0, beats: 3'd4, first: {2'd0, 8'h11}, last: {2'd3, 8'h44}};
        vecs[4] = '{sw: 1'b1, sa: 2'd3, beats: 3'd4, first: {2'd3, 8'h44}, last: {2'd2, 8'h33}};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_outputs[inst%0d]", k),
                64'({addr_a[k], rd_data_a[k], rd_addr_a[k], rd_valid_a[k], busy_a[k], done_a[k]}), 64'(0));
        end
        #1 reset = 1'b0;

        // Table: single reads and wrapping sweeps with an always-ready consumer.
        for (int v = 0; v < 5; v++) begin
            pulse_start(vecs[v].sw, vecs[v].sa);
            wait_idle(100);
            repeat (2) @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("vec%0d_beats[inst%0d]", v, k), 64'(st_beats[k]), 64'(vecs[v].beats));
                chk($sformatf("vec%0d_first[inst%0d]", v, k), 64'(st_first[k]), 64'(vecs[v].first));
                chk($sformatf("vec%0d_last[inst%0d]", v, k), 64'(st_last[k]), 64'(vecs[v].last));
                chk($sformatf("vec%0d_dones[inst%0d]", v, k), 64'(st_dones[k]), 64'(1));
                chk($sformatf("vec%0d_latency[inst%0d]", v, k), 64'(st_lat[k]), 64'((k == 0) ? 1 : 3));
            end
        end

        // Backpressure on beat 0 with a memory change during the stall.
        #1 rdy[0] = 1'b0;
        pulse_start(1'b1, 2'd0);
        wait_valid(0, 20);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(rd_valid_a[0]), 64'(1'b1));
            chk("stall_data", 64'(rd_data_a[0]), 64'(8'h11));
            if (i == 1) #1 mem[0] = 8'h99;
            @(negedge clk);
        end
        #1;
        mem[0] = 8'h11;
        rdy[0] = 1'b1;
        wait_idle(200);

        // start mid-sweep and in the final-handshake cycle is ignored;
        // start in the done cycle is accepted.
        @(negedge clk);
        #1 rdy[0] = 1'b0;
        pulse_start(1'b1, 2'd1);
        for (int b = 0; b < 4; b++) begin
            wait_valid(0, 20);
            chk("manual_beat", 64'({rd_addr_a[0], rd_data_a[0]}),
                64'({2'(b + 1), preload(2'(b + 1))}));
            #1;
            rdy[0] = 1'b1;
            if (b == 1 || b == 3) begin
                start = 1'b1; sweep = 1'b0; start_addr = 2'd2;
            end
            @(negedge clk);
            if (b == 3) begin
                chk("final_hs_start_ignored_busy", 64'(busy_a[0]), 64'(1'b0));
                chk("final_hs_done", 64'(done_a[0]), 64'(1'b1));
                #1 rdy[0] = 1'b0;
                @(negedge clk);
                chk("done_cycle_start_accepted", 64'(busy_a[0]), 64'(1'b1));
                chk("done_single_pulse", 64'(done_a[0]), 64'(1'b0));
                #1;
                start  = 1'b0;
                rdy[0] = 1'b1;
                wait_valid(0, 20);
                chk("done_cycle_read", 64'({rd_addr_a[0], rd_data_a[0]}), 64'({2'd2, 8'h33}));
            end else begin
                chk("mid_sweep_busy", 64'(busy_a[0]), 64'(1'b1));
                #1;
                rdy[0] = 1'b0;
                start  = 1'b0;
            end
        end
        wait_idle(200);

        // Reset while presenting beat 2 of a sweep.
        @(negedge clk);
        #1 rdy[0] = 1'b0;
        pulse_start(1'b1, 2'd0);
        for (int b = 0; b < 2; b++) begin
            wait_valid(0, 20);
            #1 rdy[0] = 1'b1;
            @(negedge clk);
            #1 rdy[0] = 1'b0;
        end
        wait_valid(0, 20);
        chk("beat2_addr", 64'(rd_addr_a[0]), 64'(2'd2));
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midop_reset_outputs",
            64'({addr_a[0], rd_data_a[0], rd_addr_a[0], rd_valid_a[0], busy_a[0], done_a[0]}), 64'(0));
        #1;
        reset  = 1'b0;
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("midop_reset_no_done", 64'({busy_a[0], done_a[0]}), 64'(2'b00));
        pulse_start(1'b0, 2'd3);
        wait_valid(0, 20);
        chk("after_reset_read", 64'({rd_addr_a[0], rd_data_a[0]}), 64'({2'd3, 8'h44}));
        wait_idle(200);

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            start      = ($urandom_range(3) == 0);
            sweep      = 1'($urandom_range(1));
            start_addr = 2'($urandom_range(3));
            rdy[0]     = ($urandom_range(2) != 0);
            rdy[1]     = ($urandom_range(2) != 0);
            reset      = ($urandom_range(199) == 0);
            if ($urandom_range(7) == 0) mem[2'($urandom_range(3))] = 8'($urandom);
        end
        @(negedge clk);
        #1;
        start  = 1'b0;
        reset  = 1'b0;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        wait_idle(200);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_scan_reader.md
Name: memory_scan_reader

Overview:
- Read-side controller for the 4-entry byte memory system.
- Drives the memory's 2-bit address, waits a settle time, captures the selected byte and presents it on a valid/ready output port.
- Two modes: single-address read, or a 4-beat sweep that wraps through all addresses starting at a given address.
- Sits between the memory system's addr/memory pins and a downstream consumer (LED display sequencer, serial transmitter).

Parameters:
- DATA_W, 8, width of each stored word and of the captured data.
- ADDR_W, 2, address width; number of words is 2**ADDR_W = 4.
- SETTLE_CYCLES, 1, cycles to hold addr before sampling memory. Must be >= 1; elaboration error otherwise.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a read; sampled only in IDLE.
- sweep  in  1  sampled with start: 0 = single read, 1 = read all 4 words.
- start_addr  in  ADDR_W  first address to read; sampled with start.
- addr  out  ADDR_W  address driven to the memory system.
- memory  in  DATA_W  selected byte returned by the memory system.
- rd_data  out  DATA_W  captured byte.
- rd_addr  out  ADDR_W  address that rd_data came from.
- rd_valid  out  1  rd_data/rd_addr valid.
- rd_ready  in  1  consumer accepts the current beat.
- busy  out  1  high from start acceptance until the final beat is accepted.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - All outputs 0: addr=0, rd_data=0, rd_addr=0, rd_valid=0, busy=0, done=0.
  - State returns to IDLE; settle counter and beat counter cleared.
  - Reset mid-operation abandons the transaction; no done pulse.
- FSM states: IDLE, SETTLE, PRESENT.
- IDLE:
  - busy=0 and rd_valid=0; addr holds its last value.
  - If start=1 at an edge: addr<=start_addr, mode<=sweep, beat<=0, cnt<=SETTLE_CYCLES-1, busy<=1, go to SETTLE.
- SETTLE:
  - While cnt!=0: decrement cnt.
  - At the edge where cnt==0: rd_data<=memory, rd_addr<=addr, rd_valid<=1, go to PRESENT.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- PRESENT:
  - rd_valid=1; rd_data and rd_addr stay stable until handshake (rd_valid && rd_ready at an edge).
  - No timeout; rd_ready may stay low indefinitely.
  - On handshake with mode=sweep and beat<3: beat<=beat+1, addr<=addr+1 (mod 4), cnt<=SETTLE_CYCLES-1, rd_valid<=0, go to SETTLE.
  - On handshake otherwise: rd_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
- Latency: with start accepted at edge E0, rd_valid rises after edge E0+SETTLE_CYCLES. Each sweep beat takes SETTLE_CYCLES cycles after the previous handshake, plus consumer stall.
- Sweep order wraps: start_addr=2 reads 2,3,0,1.
- The handshake edge itself captures nothing. The next beat samples memory only after a fresh settle.
- start is ignored while busy, including in the same cycle as the final handshake.
- start during the done-pulse cycle is accepted, since the block is already in IDLE.
- memory is not re-sampled in PRESENT. Changes to memory contents after capture do not alter rd_data.
- Arithmetic: address increment truncates to ADDR_W bits. The beat counter is ADDR_W bits wide and compares against 2**ADDR_W-1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SETTLE, PRESENT};
  - localparam NUM_WORDS = 2**ADDR_W;
  - defaults DATA_W=8 and ADDR_W=2, also used by the memory system.
- One natural sub-module, settle_timer:
  - loadable down-counter of width clog2(SETTLE_CYCLES) with an expire flag;
  - reused by the write-side sequencer.
- FSM and datapath registers stay in the top module.

Test Plan:
1. Reset after preloading memory [0]=0x11, [1]=0x22, [2]=0x33, [3]=0x44 -> all outputs 0. Single read, start_addr=1, rd_ready=1 -> addr=1, rd_valid rises SETTLE_CYCLES cycles after start, rd_data=0x22, rd_addr=1, done pulses once, busy falls.
2. Sweep from start_addr=2, rd_ready=1 -> beats (2,0x33),(3,0x44),(0,0x11),(1,0x22) in order; exactly 4 valid beats; one done pulse.
3. Backpressure: rd_ready held low 5 cycles during beat 0 -> rd_valid stays 1 and rd_data stays 0x11. Change memory[0] to 0x99 during the stall -> rd_data remains 0x11.
4. start pulsed mid-sweep and in the final-handshake cycle -> ignored; sweep completes normally. start in the done cycle -> new transaction begins.
5. reset asserted while in PRESENT of beat 2 -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent single read returns correct data.
6. SETTLE_CYCLES=3 -> rd_valid rises exactly 3 cycles after start acceptance, and 3 cycles after each sweep handshake.
